alu_exec_unit: RTL

Multi-cycle execute stage that consumes the 3-bit ALU control code and the two operands, and returns a registered result with a zero flag over valid/ready handshakes. It is the receiving end of the ALU decoder's control output, used where the datapath is staged rather than single-cycle. Arithmetic and logic ops take one cycle. Shifts run one bit per cycle under a counter, so no barrel shifter is needed.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 39 +++
 rtl/alu_exec_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the decoder and the
// execute stage, plus the execute-stage FSM state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } exec_state_e;

    // Shifts are iterated one bit per cycle; every other code finishes in one cycle.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU for the non-shift operations.
// Shift codes produce zero here; the execute stage handles them iteratively.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic             lt_signed;

    // Signed less-than: sign of (a-b) corrected by the subtraction overflow,
    // so extreme operands (e.g. max positive vs. min negative) compare correctly.
    always_comb begin
        diff      = a_i - b_i;
        sub_ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
        lt_signed = diff[WIDTH-1] ^ sub_ovf;
    end

    // Operation select.
    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = diff;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {{(WIDTH-1){1'b0}}, lt_signed};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage with valid/ready handshakes on both sides.
// Add/sub/and/or/slt take one EXEC cycle; shifts step one bit per cycle.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | in_ready=1, waiting for a request; operands latched on accept
//   EXEC    | computing; shifts stay here while more than one bit remains
//   DONE    | out_valid=1, result/zero held until out_ready
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_control,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    exec_state_e        state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;

    logic [WIDTH-1:0]   core_y;
    logic [WIDTH-1:0]   shift_step;
    logic               op_is_shift;
    logic               accept;

    // The accumulator still holds operand A during a non-shift EXEC cycle,
    // so it doubles as the core's A input.
    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i (op_q),
        .a_i  (acc_q),
        .b_i  (b_q),
        .y_o  (core_y)
    );

    assign op_is_shift = is_shift_op(op_q);
    assign accept      = (state_q == ST_IDLE) && in_valid;

    // One-bit shift of the accumulator in the direction/fill the opcode selects.
    always_comb begin
        shift_step = acc_q;
        case (op_q)
            ALU_SLL: shift_step = {acc_q[WIDTH-2:0], 1'b0};
            ALU_SRL: shift_step = {1'b0, acc_q[WIDTH-1:1]};
            ALU_SRA: shift_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: shift_step = acc_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (!op_is_shift || (cnt_q <= CNT_ONE)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; the two are mutually exclusive.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath next values: operand capture on accept, iteration in EXEC.
    always_comb begin
        op_d     = op_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;

        if (accept) begin
            op_d  = alu_control;
            acc_d = src_a;
            b_d   = src_b;
            cnt_d = src_b[SHAMT_W-1:0];
        end else if (state_q == ST_EXEC) begin
            if (!op_is_shift) begin
                result_d = core_y;
                zero_d   = (core_y == '0);
            end else if (cnt_q > CNT_ONE) begin
                acc_d = shift_step;
                cnt_d = cnt_q - CNT_ONE;
            end else if (cnt_q == CNT_ONE) begin
                result_d = shift_step;
                zero_d   = (shift_step == '0);
                cnt_d    = '0;
            end else begin
                result_d = acc_q;
                zero_d   = (acc_q == '0);
            end
        end
    end

    // Datapath registers; zero is registered alongside result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= ALU_ADD;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            op_q     <= op_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule
